// File: rtl/core_seq_if.sv
// Pin bundle between the sequencer and the SRAM macros / corelet.
// The master side (core_seq) drives every control pin and observes the output FIFO status.
interface core_seq_if #(
    parameter int AW = 11
);
    logic          xmem_cen;
    logic          xmem_wen;
    logic [AW-1:0] xmem_addr;
    logic          pmem_cen;
    logic          pmem_wen;
    logic [AW-1:0] pmem_addr;
    logic          l0_wr;
    logic          load;
    logic          execute;
    logic          ofifo_rd;
    logic          ofifo_valid;

    modport master (
        output xmem_cen, xmem_wen, xmem_addr,
        output pmem_cen, pmem_wen, pmem_addr,
        output l0_wr, load, execute, ofifo_rd,
        input  ofifo_valid
    );

    modport slave (
        input  xmem_cen, xmem_wen, xmem_addr,
        input  pmem_cen, pmem_wen, pmem_addr,
        input  l0_wr, load, execute, ofifo_rd,
        output ofifo_valid
    );
endinterface

// File: rtl/core_seq.sv
// Instruction sequencer for the systolic core: one start runs weight fetch, kernel load,
// activation fetch, execute and output drain for every kernel tile of the command.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | config captured; skip to FIN on an empty command
// WFETCH | read COL weight vectors of the current tile into L0
// KLOAD  | corelet kernel load, ROW+COL cycles
// XFETCH | read N activation vectors into L0
// EXEC   | corelet execute, N+ROW+COL cycles; output writes allowed
// DRAIN  | wait for the tile's N output writes to complete
// FIN    | one-cycle done pulse
module core_seq #(
    parameter int ROW = 8,
    parameter int COL = 8,
    parameter int AW  = 11,
    parameter int NW  = 11,
    parameter int TW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] cfg_w_base,
    input  logic [AW-1:0] cfg_x_base,
    input  logic [AW-1:0] cfg_out_base,
    input  logic [NW-1:0] cfg_n_x,
    input  logic [TW-1:0] cfg_tiles,
    output logic          busy,
    output logic          done,
    core_seq_if.master    bus
);

    localparam int CW = NW + $clog2(ROW + COL + 1) + 1;
    localparam logic [CW-1:0] WF_LAST  = CW'(COL - 1);
    localparam logic [CW-1:0] KL_LAST  = CW'(ROW + COL - 1);
    localparam logic [CW-1:0] EX_EXTRA = CW'(ROW + COL);
    localparam logic [AW-1:0] COL_AW   = AW'(COL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WFETCH,
        S_KLOAD,
        S_XFETCH,
        S_EXEC,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [NW-1:0] k_q, k_d;
    logic [AW-1:0] xaddr_q, xaddr_d;
    logic [AW-1:0] wtb_q, wtb_d;
    logic [AW-1:0] obase_q, obase_d;
    logic [AW-1:0] xb_q, xb_d;
    logic [NW-1:0] n_q, n_d;
    logic [TW-1:0] tiles_q, tiles_d;
    logic          l0_wr_q, l0_wr_d;

    logic rd_en;
    logic wr_en;
    logic last_tile;

    assign rd_en     = (state_q == S_WFETCH) || (state_q == S_XFETCH);
    assign wr_en     = ((state_q == S_EXEC) || (state_q == S_DRAIN)) && bus.ofifo_valid && (k_q < n_q);
    assign last_tile = ((TW + 1)'(tile_q) + (TW + 1)'(1)) == (TW + 1)'(tiles_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tile_d  = tile_q;
        k_d     = k_q;
        xaddr_d = xaddr_q;
        wtb_d   = wtb_q;
        obase_d = obase_q;
        xb_d    = xb_q;
        n_d     = n_q;
        tiles_d = tiles_q;
        // SRAM read data appears one cycle after the read, so the L0 write trails it.
        l0_wr_d = rd_en;

        if (wr_en) begin
            k_d = k_q + 1'b1;
        end
        if (rd_en) begin
            xaddr_d = xaddr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wtb_d   = cfg_w_base;
                    xb_d    = cfg_x_base;
                    obase_d = cfg_out_base;
                    n_d     = cfg_n_x;
                    tiles_d = cfg_tiles;
                    tile_d  = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((n_q == '0) || (tiles_q == '0)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_WFETCH;
                    cnt_d   = WF_LAST;
                    xaddr_d = wtb_q;
                    k_d     = '0;
                end
            end
            S_WFETCH: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_KLOAD;
                    cnt_d   = KL_LAST;
                end
            end
            S_KLOAD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_XFETCH;
                    cnt_d   = CW'(n_q) - 1'b1;
                    xaddr_d = xb_q;
                end
            end
            S_XFETCH: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = CW'(n_q) + EX_EXTRA - 1'b1;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (k_q == n_q) begin
                    if (last_tile) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_WFETCH;
                        tile_d  = tile_q + 1'b1;
                        wtb_d   = wtb_q + COL_AW;
                        xaddr_d = wtb_q + COL_AW;
                        obase_d = obase_q + AW'(n_q);
                        k_d     = '0;
                        cnt_d   = WF_LAST;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tile_q  <= '0;
            k_q     <= '0;
            xaddr_q <= '0;
            wtb_q   <= '0;
            obase_q <= '0;
            xb_q    <= '0;
            n_q     <= '0;
            tiles_q <= '0;
            l0_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            k_q     <= k_d;
            xaddr_q <= xaddr_d;
            wtb_q   <= wtb_d;
            obase_q <= obase_d;
            xb_q    <= xb_d;
            n_q     <= n_d;
            tiles_q <= tiles_d;
            l0_wr_q <= l0_wr_d;
        end
    end

    assign bus.xmem_cen  = ~rd_en;
    assign bus.xmem_wen  = 1'b1;
    assign bus.xmem_addr = rd_en ? xaddr_q : '0;
    assign bus.pmem_cen  = ~wr_en;
    assign bus.pmem_wen  = ~wr_en;
    assign bus.pmem_addr = wr_en ? (obase_q + AW'(k_q)) : '0;
    assign bus.l0_wr     = l0_wr_q;
    assign bus.load      = (state_q == S_KLOAD);
    assign bus.execute   = (state_q == S_EXEC);
    assign bus.ofifo_rd  = wr_en;
    assign busy          = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done          = (state_q == S_FIN);

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: expected SRAM addresses are queued when a command is issued
// and popped as the sequencer performs each read or write.
module tb_core_seq;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int NW  = 11;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_w_base = '0;
    logic [AW-1:0] cfg_x_base = '0;
    logic [AW-1:0] cfg_out_base = '0;
    logic [NW-1:0] cfg_n_x = '0;
    logic [TW-1:0] cfg_tiles = '0;
    logic          busy;
    logic          done;
    logic          valid_r = 1'b0;

    core_seq_if #(.AW(AW)) bus ();
    assign bus.ofifo_valid = valid_r;

    core_seq #(.ROW(ROW), .COL(COL), .AW(AW), .NW(NW), .TW(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_w_base   (cfg_w_base),
        .cfg_x_base   (cfg_x_base),
        .cfg_out_base (cfg_out_base),
        .cfg_n_x      (cfg_n_x),
        .cfg_tiles    (cfg_tiles),
        .busy         (busy),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int n_xrd, n_wr, n_l0, n_load, n_exec, n_done, n_busy;
    logic prev_rd = 1'b0;
    int xq[$];
    int pq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_rd = 1'b0;
        end else begin
            if (prev_rd || bus.l0_wr) check("l0_wr_lag", bus.l0_wr, prev_rd);
            if (!bus.xmem_cen) begin
                n_xrd++;
                check("xmem_wen_high", bus.xmem_wen, 1);
                check("xrd_expected", (xq.size() > 0), 1);
                if (xq.size() > 0) check("xrd_addr", bus.xmem_addr, xq.pop_front());
            end
            if (!bus.pmem_cen) begin
                n_wr++;
                check("pmem_wen_low", bus.pmem_wen, 0);
                check("pop_with_write", bus.ofifo_rd, 1);
                check("excl_xmem_idle", bus.xmem_cen, 1);
                check("wr_expected", (pq.size() > 0), 1);
                if (pq.size() > 0) check("wr_addr", bus.pmem_addr, pq.pop_front());
            end
            if (bus.ofifo_rd) check("pop_needs_valid", bus.ofifo_valid, 1);
            if (bus.l0_wr) n_l0++;
            if (bus.load) n_load++;
            if (bus.execute) n_exec++;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("busy_low_in_fin", busy, 0);
            end
            prev_rd = ~bus.xmem_cen;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        n_xrd = 0; n_wr = 0; n_l0 = 0; n_load = 0; n_exec = 0; n_done = 0; n_busy = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic issue(input int wb, input int xb, input int ob, input int n, input int t);
        cfg_w_base = AW'(wb);
        cfg_x_base = AW'(xb);
        cfg_out_base = AW'(ob);
        cfg_n_x = NW'(n);
        cfg_tiles = TW'(t);
        for (int ti = 0; ti < t; ti++) begin
            for (int i = 0; i < COL; i++) xq.push_back((wb + ti * COL + i) % (1 << AW));
            for (int j = 0; j < n; j++) xq.push_back((xb + j) % (1 << AW));
        end
        for (int ti = 0; ti < t; ti++)
            for (int k = 0; k < n; k++) pq.push_back((ob + ti * n + k) % (1 << AW));
        clear_counts();
        pulse_start();
    endtask

    task automatic wait_exec(input int bound);
        int i = 0;
        while (!bus.execute && i < bound) begin
            step(1);
            i++;
        end
        check("exec_reached", bus.execute, 1);
    endtask

    task automatic wait_done(input int bound);
        int i = 0;
        while (n_done == 0 && i < bound) begin
            step(1);
            i++;
        end
        check("done_reached", (n_done > 0), 1);
    endtask

    task automatic check_pass(input string tag, input int n, input int t);
        check({tag, "_xq_empty"}, xq.size(), 0);
        check({tag, "_pq_empty"}, pq.size(), 0);
        check({tag, "_reads"}, n_xrd, t * (COL + n));
        check({tag, "_l0_wr"}, n_l0, t * (COL + n));
        check({tag, "_load"}, n_load, t * (ROW + COL));
        check({tag, "_exec"}, n_exec, t * (n + ROW + COL));
        check({tag, "_writes"}, n_wr, t * n);
        check({tag, "_done_once"}, n_done, 1);
        check({tag, "_busy_cont"}, n_busy, done_cyc - start_cyc - 1);
    endtask

    int w0;

    initial begin
        clear_counts();
        step(3);
        check("rst_xmem_cen", bus.xmem_cen, 1);
        check("rst_xmem_wen", bus.xmem_wen, 1);
        check("rst_pmem_cen", bus.pmem_cen, 1);
        check("rst_pmem_wen", bus.pmem_wen, 1);
        check("rst_xmem_addr", bus.xmem_addr, 0);
        check("rst_pmem_addr", bus.pmem_addr, 0);
        check("rst_ctrl", {bus.l0_wr, bus.load, bus.execute, bus.ofifo_rd, busy, done}, 0);
        reset = 1'b0;
        step(2);

        // single tile
        issue(0, 16, 100, 36, 1);
        check("t1_busy_after_start", busy, 1);
        wait_exec(200);
        valid_r = 1'b1;
        wait_done(400);
        step(5);
        check_pass("t1", 36, 1);
        valid_r = 1'b0;

        // two tiles reuse activations
        issue(0, 16, 100, 36, 2);
        wait_exec(200);
        valid_r = 1'b1;
        wait_done(800);
        step(5);
        check_pass("t2", 36, 2);
        valid_r = 1'b0;

        // backpressure with a long stall reaching DRAIN
        issue(0, 16, 100, 36, 1);
        wait_exec(200);
        valid_r = 1'b1; step(20);
        valid_r = 1'b0; step(1);
        valid_r = 1'b1; step(1);
        valid_r = 1'b0; step(1);
        w0 = n_wr;
        check("bp_writes_before_stall", w0, 21);
        step(50);
        check("bp_no_write_in_stall", n_wr, w0);
        check("bp_busy_in_stall", busy, 1);
        check("bp_in_drain", bus.execute, 0);
        check("bp_no_done_in_stall", n_done, 0);
        valid_r = 1'b1;
        wait_done(400);
        step(5);
        check_pass("bp", 36, 1);
        valid_r = 1'b0;

        // zero-length command
        issue(0, 16, 100, 0, 3);
        wait_done(20);
        step(5);
        check("zl_done_latency", done_cyc - start_cyc, 2);
        check("zl_no_reads", n_xrd, 0);
        check("zl_no_writes", n_wr, 0);
        check("zl_no_corelet", n_load + n_exec + n_l0, 0);
        check("zl_done_once", n_done, 1);
        xq.delete();
        pq.delete();

        // reset in the middle of EXEC
        issue(0, 16, 100, 36, 1);
        wait_exec(200);
        valid_r = 1'b1;
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        check("mr_xmem_cen", bus.xmem_cen, 1);
        check("mr_pmem_cen", bus.pmem_cen, 1);
        check("mr_pmem_wen", bus.pmem_wen, 1);
        check("mr_addrs", {bus.xmem_addr, bus.pmem_addr}, 0);
        check("mr_ctrl", {bus.l0_wr, bus.load, bus.execute, bus.ofifo_rd, busy, done}, 0);
        check("mr_reads_done", xq.size(), 0);
        pq.delete();
        w0 = n_wr;
        step(6);
        check("mr_no_more_writes", n_wr, w0);
        valid_r = 1'b0;
        issue(0, 16, 100, 36, 1);
        wait_exec(200);
        valid_r = 1'b1;
        wait_done(400);
        step(5);
        check_pass("mr_clean", 36, 1);
        valid_r = 1'b0;

        // start while busy ignored; output address wraps
        issue(0, 16, 2040, 16, 1);
        begin
            int i = 0;
            while (n_xrd < 12 && i < 100) begin
                step(1);
                i++;
            end
        end
        check("sb_in_xfetch", n_xrd, 12);
        cfg_out_base = AW'(500);
        cfg_n_x = NW'(3);
        @(posedge clk);
        #1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_exec(200);
        valid_r = 1'b1;
        wait_done(400);
        step(20);
        check_pass("sb", 16, 1);
        check("sb_idle_after", busy, 0);
        valid_r = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Parametrised instruction sequencer for the systolic core. Replaces the hand-driven instruction word with an internal FSM.
- A single start command runs a full convolution pass:
  - weight fetch into L0
  - kernel load
  - activation fetch
  - execute
  - output-FIFO drain into output SRAM
- Supports multiple kernel tiles per command, reusing the same activations. Drives the input-SRAM, output-SRAM and corelet control pins directly.

Parameters:
- ROW, 8, array rows (activation vector lanes).
- COL, 8, array columns (weight vectors per tile).
- AW, 11, SRAM address width (both memories).
- NW, 11, width of activation-count field.
- TW, 4, width of tile-count field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle command pulse, sampled in IDLE only
- cfg_w_base  in  AW  input-SRAM address of tile-0 weight vector 0
- cfg_x_base  in  AW  input-SRAM address of activation vector 0
- cfg_out_base  in  AW  output-SRAM address of tile-0 output 0
- cfg_n_x  in  NW  activation vectors per tile (N)
- cfg_tiles  in  TW  kernel tiles (T)
- ofifo_valid  in  1  corelet output FIFO has a word (first-word-fall-through)
- xmem_cen  out  1  input SRAM chip enable, active low
- xmem_wen  out  1  input SRAM write enable, active low; always 1 (read-only)
- xmem_addr  out  AW  input SRAM address
- pmem_cen  out  1  output SRAM chip enable, active low
- pmem_wen  out  1  output SRAM write enable, active low
- pmem_addr  out  AW  output SRAM address
- l0_wr  out  1  write current xmem Q into L0
- load  out  1  corelet kernel-load
- execute  out  1  corelet execute
- ofifo_rd  out  1  pop output FIFO
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset state:
  - FSM in IDLE; all counters 0.
  - xmem_cen=pmem_cen=pmem_wen=xmem_wen=1; addresses 0.
  - l0_wr=load=execute=ofifo_rd=busy=done=0.
  - Reset mid-operation aborts immediately to this state; no further SRAM access.
- Configuration capture: cfg_* are captured on the accepted start. Later changes have no effect until the next command.
- Command acceptance:
  - start in IDLE: busy=1 from the next cycle.
  - start while busy: ignored.
  - cfg_n_x=0 or cfg_tiles=0: go straight to FIN. No SRAM or corelet activity.
- States (per tile t = 0..T-1):
  - WFETCH: COL cycles.
    - Cycle i: xmem_cen=0, xmem_addr = w_base + t*COL + i.
    - SRAM read latency is 1 cycle, so l0_wr=1 exactly one cycle after each read: COL l0_wr pulses, the last in the first cycle of KLOAD.
  - KLOAD: load=1 for ROW+COL cycles, then go to XFETCH.
  - XFETCH: N cycles.
    - Cycle j: xmem_cen=0, xmem_addr = x_base + j.
    - l0_wr delayed by 1, as in WFETCH.
  - EXEC: execute=1 for N+ROW+COL cycles.
  - DRAIN: remain until the tile's written count reaches N, then go to the next tile's WFETCH, or to FIN after the last tile.
  - FIN: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- Output write path (active in EXEC and DRAIN):
  - Write condition: ofifo_valid=1 and the tile's written count k < N.
  - When met, in the same cycle: ofifo_rd=1, pmem_cen=0, pmem_wen=0, pmem_addr = out_base + t*N + k. Then k increments.
  - At most one write per cycle. ofifo_valid while k==N does not pop.
- Address arithmetic: modulo 2^AW; wrap-around is silent and permitted.
- Exclusivity: xmem and pmem are never both idle-enabled incorrectly. xmem accesses occur only in WFETCH/XFETCH; pmem accesses only in EXEC/DRAIN.
- Outputs are registered or depend only on state and counters, except ofifo_rd/pmem_* which may depend combinationally on ofifo_valid.

Test Plan:
- Single tile: ROW=COL=8, w_base=0, x_base=16, out_base=100, N=36, T=1, ofifo_valid tied 1 from EXEC entry.
  - Reads 0..7 then 16..51.
  - 44 l0_wr pulses.
  - load high 16 cycles, execute high 52 cycles.
  - Writes to 100..135 exactly once each.
  - done pulses once.
- Two tiles, same config with T=2:
  - Weight reads 0..7 then 8..15; activations 16..51 read twice.
  - Writes to 100..171.
  - busy high continuously until done.
- Backpressure: ofifo_valid toggles 1-0-1-0 and stays 0 for 50 cycles mid-drain.
  - No pop or write while valid=0.
  - FSM holds in DRAIN; completes with 36 writes, no duplicates or gaps.
- Zero length: N=0, T=3.
  - done exactly 2 cycles after start.
  - xmem_cen and pmem_cen stay 1 throughout.
- Reset mid-EXEC: assert reset 1 cycle.
  - Next cycle all outputs at reset values, busy=0.
  - A subsequent start runs a clean pass.
- Start while busy plus address wrap:
  - Second start pulse during XFETCH is ignored (one done only).
  - out_base=2040 with N=16 writes 2040..2047 then 0..7.
